rr_req_arbiter16: RTL

Round-robin request arbiter that sits directly upstream of the 16-to-4 one-hot encoder. It captures rising edges on 16 request lines into a pending register and selects one pending line per arbitration using a rotating priority. It presents the winner as a registered one-hot grant with a valid/ready handshake. Its grant vector is the encoder's input, so the grant is guaranteed strictly one-hot or all-zero.

---
 rtl/rr_req_arbiter16_pkg.sv | 15 +
 rtl/rr_req_arbiter16_if.sv | 32 +++
 rtl/rr_req_arbiter16_pick.sv | 33 +++
 rtl/rr_req_arbiter16.sv | 112 +++++++++++
 4 files changed

// File: rtl/rr_req_arbiter16_pkg.sv
// Shared constants and types for the 16-line round-robin request arbiter.
// Optional build macro: RR_REQ_ARBITER16_INDEX_EN (adds a binary grant index).
package rr_arb_pkg;

   localparam int ARB_N    = 16;
   localparam int ARB_IDXW = 4;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_OFFER = 1'b1
   } arb_state_t;

   localparam logic [ARB_IDXW-1:0] ARB_PTR_RST = ARB_IDXW'(ARB_N - 1);

endpackage

// File: rtl/rr_req_arbiter16_if.sv
// Grant handshake bundle between the arbiter and its consumer.
// RR_REQ_ARBITER16_INDEX_EN adds the registered binary winner index.
interface rr_req_arbiter16_if #(
   parameter int N = 16
);

   logic [N-1:0]         grant;
   logic                 grant_valid;
   logic                 grant_ready;
`ifdef RR_REQ_ARBITER16_INDEX_EN
   logic [$clog2(N)-1:0] grant_idx;
`endif

   modport master (
      output grant,
      output grant_valid,
`ifdef RR_REQ_ARBITER16_INDEX_EN
      output grant_idx,
`endif
      input  grant_ready
   );

   modport slave (
      input  grant,
      input  grant_valid,
`ifdef RR_REQ_ARBITER16_INDEX_EN
      input  grant_idx,
`endif
      output grant_ready
   );

endinterface

// File: rtl/rr_req_arbiter16_pick.sv
// Combinational rotated-priority search: first pending bit above last_ptr.
// N must be a power of two so the index addition wraps naturally.
module rr_pick
   import rr_arb_pkg::*;
#(
   parameter int N    = ARB_N,
   parameter int IDXW = $clog2(N)
) (
   input  logic [N-1:0]    pending_i,
   input  logic [IDXW-1:0] last_ptr_i,
   output logic [N-1:0]    pick_o,
   output logic [IDXW-1:0] pick_idx_o,
   output logic            any_o
);

   logic [IDXW-1:0] idx;

   always_comb begin
      pick_o     = '0;
      pick_idx_o = '0;
      any_o      = 1'b0;
      idx        = '0;
      for (int i = 0; i < N; i++) begin
         idx = last_ptr_i + IDXW'(1) + IDXW'(i);
         if (!any_o && pending_i[idx]) begin
            any_o       = 1'b1;
            pick_idx_o  = idx;
            pick_o[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_req_arbiter16.sv
// Round-robin arbiter: captures request edges, offers a one-hot grant.
// RR_REQ_ARBITER16_INDEX_EN exposes the registered winner index.
module rr_req_arbiter16
   import rr_arb_pkg::*;
#(
   parameter int N    = ARB_N,
   parameter int IDXW = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req_i,
   output logic [N-1:0]         pending_o,
   output logic                 drop_o,
   rr_req_arbiter16_if.master   gnt_if
);

   localparam logic [IDXW-1:0] PTR_RST = IDXW'(N - 1);

   logic [N-1:0]    req_q;
   logic [N-1:0]    pend_q, pend_d;
   logic [N-1:0]    grant_q, grant_d;
   logic            gv_q, gv_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [IDXW-1:0] last_ptr_q, last_ptr_d;
   logic            drop_q, drop_d;
   arb_state_t      state_q, state_d;

   logic [N-1:0]    rise;
   logic [N-1:0]    clr;
   logic            accept;
   logic [N-1:0]    pick;
   logic [IDXW-1:0] pick_idx;
   logic            any;

   rr_pick #(
      .N    (N),
      .IDXW (IDXW)
   ) u_pick (
      .pending_i  (pend_q),
      .last_ptr_i (last_ptr_q),
      .pick_o     (pick),
      .pick_idx_o (pick_idx),
      .any_o      (any)
   );

   assign accept = (state_q == ARB_OFFER) && gnt_if.grant_ready;
   assign clr    = accept ? grant_q : '0;
   assign rise   = req_i & ~req_q;

   // A new edge on a bit being cleared this cycle re-arms it.
   assign pend_d = (pend_q & ~clr) | rise;
   assign drop_d = |(rise & pend_q & ~clr);

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      gv_d       = gv_q;
      idx_d      = idx_q;
      last_ptr_d = last_ptr_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (any) begin
               grant_d = pick;
               gv_d    = 1'b1;
               idx_d   = pick_idx;
               state_d = ARB_OFFER;
            end
         end
         ARB_OFFER: begin
            if (gnt_if.grant_ready) begin
               last_ptr_d = idx_q;
               grant_d    = '0;
               gv_d       = 1'b0;
               idx_d      = '0;
               state_d    = ARB_IDLE;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q      <= '0;
         pend_q     <= '0;
         grant_q    <= '0;
         gv_q       <= 1'b0;
         idx_q      <= '0;
         last_ptr_q <= PTR_RST;
         drop_q     <= 1'b0;
         state_q    <= ARB_IDLE;
      end else begin
         req_q      <= req_i;
         pend_q     <= pend_d;
         grant_q    <= grant_d;
         gv_q       <= gv_d;
         idx_q      <= idx_d;
         last_ptr_q <= last_ptr_d;
         drop_q     <= drop_d;
         state_q    <= state_d;
      end
   end

   assign pending_o          = pend_q;
   assign drop_o             = drop_q;
   assign gnt_if.grant       = grant_q;
   assign gnt_if.grant_valid = gv_q;
`ifdef RR_REQ_ARBITER16_INDEX_EN
   assign gnt_if.grant_idx   = idx_q;
`endif

endmodule
